// File: rtl/uart_rx_checker.sv
// 8N1 UART receiver that checks incoming bytes form a +1 mod-256 sequence.
// It counts good bytes, sequence errors and framing errors for link-health reporting.
module uart_rx_checker #(
    parameter int CLK_DIV = 434,
    parameter int ERR_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx,
    input  logic             clear,
    output logic [7:0]       rx_byte,
    output logic             rx_ready,
    output logic             frame_err,
    output logic             seq_err,
    output logic             locked,
    output logic [31:0]      byte_count,
    output logic [ERR_W-1:0] seq_err_count,
    output logic [ERR_W-1:0] frame_err_count
);
    localparam logic [15:0]      BIT_LAST  = 16'(CLK_DIV - 1);
    localparam logic [15:0]      HALF_LAST = 16'(CLK_DIV / 2 - 1);
    localparam logic [ERR_W-1:0] ERR_ONE   = {{(ERR_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

    state_t           state_reg, state_next;
    logic [15:0]      timer_reg, timer_next;
    logic [2:0]       bit_idx_reg, bit_idx_next;
    logic [7:0]       shift_reg, shift_next;
    logic             rx_meta_reg, rx_s_reg;
    logic             byte_done, stop_bad;

    logic [7:0]       rx_byte_reg, expected_reg;
    logic             rx_ready_reg, frame_err_reg, seq_err_reg, locked_reg;
    logic [31:0]      byte_count_reg;
    logic [ERR_W-1:0] seq_err_count_reg, frame_err_count_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_reg <= 1'b1;
            rx_s_reg    <= 1'b1;
            state_reg   <= S_IDLE;
            timer_reg   <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
        end else begin
            rx_meta_reg <= rx;
            rx_s_reg    <= rx_meta_reg;
            state_reg   <= state_next;
            timer_reg   <= timer_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
        end
    end

    // Timer free-runs inside a state and is zeroed on every transition.
    always_comb begin
        state_next   = state_reg;
        timer_next   = timer_reg + 16'd1;
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        byte_done    = 1'b0;
        stop_bad     = 1'b0;
        case (state_reg)
            S_IDLE: begin
                timer_next = '0;
                if (!rx_s_reg) state_next = S_START;
            end
            S_START: begin
                if (timer_reg == HALF_LAST) begin
                    timer_next   = '0;
                    bit_idx_next = '0;
                    state_next   = rx_s_reg ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (timer_reg == BIT_LAST) begin
                    timer_next   = '0;
                    shift_next   = {rx_s_reg, shift_reg[7:1]};
                    bit_idx_next = bit_idx_reg + 3'd1;
                    if (bit_idx_reg == 3'd7) state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (timer_reg == BIT_LAST) begin
                    timer_next = '0;
                    if (rx_s_reg) begin
                        byte_done  = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        stop_bad   = 1'b1;
                        state_next = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                timer_next = '0;
                if (rx_s_reg) state_next = S_IDLE;
            end
            default: begin
                timer_next = '0;
                state_next = S_IDLE;
            end
        endcase
    end

    // seq_err is decided alongside rx_ready; the counters then settle at the
    // end of the rx_ready cycle so a clear in that cycle takes priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_byte_reg         <= '0;
            rx_ready_reg        <= 1'b0;
            frame_err_reg       <= 1'b0;
            seq_err_reg         <= 1'b0;
            locked_reg          <= 1'b0;
            expected_reg        <= '0;
            byte_count_reg      <= '0;
            seq_err_count_reg   <= '0;
            frame_err_count_reg <= '0;
        end else begin
            rx_ready_reg  <= byte_done;
            frame_err_reg <= stop_bad;
            seq_err_reg   <= byte_done && locked_reg && !clear && (shift_reg != expected_reg);
            if (byte_done) rx_byte_reg <= shift_reg;

            if (clear) begin
                locked_reg          <= 1'b0;
                expected_reg        <= '0;
                byte_count_reg      <= '0;
                seq_err_count_reg   <= '0;
                frame_err_count_reg <= '0;
            end else begin
                if (rx_ready_reg) begin
                    locked_reg     <= 1'b1;
                    expected_reg   <= rx_byte_reg + 8'd1;
                    byte_count_reg <= byte_count_reg + 32'd1;
                    if (seq_err_reg && seq_err_count_reg != '1)
                        seq_err_count_reg <= seq_err_count_reg + ERR_ONE;
                end
                if (stop_bad && frame_err_count_reg != '1)
                    frame_err_count_reg <= frame_err_count_reg + ERR_ONE;
            end
        end
    end

    assign rx_byte         = rx_byte_reg;
    assign rx_ready        = rx_ready_reg;
    assign frame_err       = frame_err_reg;
    assign seq_err         = seq_err_reg;
    assign locked          = locked_reg;
    assign byte_count      = byte_count_reg;
    assign seq_err_count   = seq_err_count_reg;
    assign frame_err_count = frame_err_count_reg;
endmodule

// File: tb/tb_uart_rx_checker.sv
// Directed bench for uart_rx_checker: frames are serialised onto rx, expected
// bytes are queued as they are sent and matched when rx_ready pulses.
module tb_uart_rx_checker;
    localparam int CLK_DIV = 16;
    localparam int ERR_W   = 4;
    localparam int ERR_MAX = (1 << ERR_W) - 1;

    logic             clk = 1'b0;
    logic             reset, rx, clear;
    logic [7:0]       rx_byte;
    logic             rx_ready, frame_err, seq_err, locked;
    logic [31:0]      byte_count;
    logic [ERR_W-1:0] seq_err_count, frame_err_count;

    uart_rx_checker #(.CLK_DIV(CLK_DIV), .ERR_W(ERR_W)) dut (
        .clk(clk), .reset(reset), .rx(rx), .clear(clear),
        .rx_byte(rx_byte), .rx_ready(rx_ready), .frame_err(frame_err),
        .seq_err(seq_err), .locked(locked), .byte_count(byte_count),
        .seq_err_count(seq_err_count), .frame_err_count(frame_err_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] b;
        logic       se;
    } exp_t;
    exp_t sb[$];

    int vectors = 0, miscompares = 0;
    logic       locked_m = 1'b0;
    logic [7:0] exp_m    = 8'h00;
    int bc_m = 0, sec_m = 0, fec_m = 0;
    int fe_pulses = 0, fe_exp = 0;
    int lat_start = -1, lat_seen = -1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Output monitor: pops the scoreboard on each rx_ready pulse.
    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b0) begin
            if (frame_err === 1'b1) fe_pulses++;
            if (seq_err === 1'b1 && rx_ready !== 1'b1)
                check("seq_err_without_ready", {31'b0, rx_ready}, 32'd1);
            if (rx_ready === 1'b1) begin
                if (lat_start >= 0 && lat_seen < 0) lat_seen = cyc - lat_start;
                if (sb.size() == 0) begin
                    check("unexpected_rx_ready", {31'b0, rx_ready}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("rx_byte", {24'b0, rx_byte}, {24'b0, e.b});
                    check("seq_err", {31'b0, seq_err}, {31'b0, e.se});
                end
            end
        end
    end

    task automatic model_clear();
        locked_m = 1'b0;
        exp_m    = 8'h00;
        bc_m     = 0;
        sec_m    = 0;
        fec_m    = 0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        exp_t e;
        if (stop_bit) begin
            e.b  = b;
            e.se = locked_m && (b != exp_m);
            if (e.se && sec_m < ERR_MAX) sec_m++;
            exp_m    = b + 8'd1;
            locked_m = 1'b1;
            bc_m++;
            sb.push_back(e);
        end
        @(negedge clk);
        rx = 1'b0;
        if (lat_start < 0) lat_start = cyc;
        repeat (CLK_DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CLK_DIV) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CLK_DIV) @(negedge clk);
        if (stop_bit) repeat (4) @(negedge clk);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_clear();
    endtask

    task automatic check_state(input string tag);
        check({tag, ".locked"}, {31'b0, locked}, {31'b0, locked_m});
        check({tag, ".byte_count"}, byte_count, 32'(bc_m));
        check({tag, ".seq_err_count"}, 32'(seq_err_count), 32'(sec_m));
        check({tag, ".frame_err_count"}, 32'(frame_err_count), 32'(fec_m));
        check({tag, ".frame_err_pulses"}, 32'(fe_pulses), 32'(fe_exp));
        check({tag, ".scoreboard_drained"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        logic hit;
        reset = 1'b1;
        rx    = 1'b1;
        clear = 1'b0;
        repeat (3) @(negedge clk);
        check("reset.rx_ready", {31'b0, rx_ready}, 32'd0);
        check("reset.rx_byte", {24'b0, rx_byte}, 32'd0);
        check("reset.seq_err", {31'b0, seq_err}, 32'd0);
        check("reset.frame_err", {31'b0, frame_err}, 32'd0);
        check_state("reset");
        reset = 1'b0;
        repeat (CLK_DIV) @(negedge clk);

        // Basic sequence and latency
        send_frame(8'h55, 1'b1);
        send_frame(8'h56, 1'b1);
        send_frame(8'h57, 1'b1);
        check("latency_window", 32'((lat_seen >= 154) && (lat_seen <= 156)), 32'd1);
        check_state("seq_55");

        // Modulo-256 wrap
        do_clear();
        send_frame(8'hFE, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h00, 1'b1);
        send_frame(8'h01, 1'b1);
        check_state("wrap");

        // Single sequence error followed by resync
        do_clear();
        send_frame(8'h10, 1'b1);
        send_frame(8'h11, 1'b1);
        send_frame(8'h20, 1'b1);
        send_frame(8'h21, 1'b1);
        check_state("resync");

        // Framing error with a long break
        do_clear();
        send_frame(8'h6B, 1'b0);
        fec_m++;
        fe_exp++;
        repeat (40 * CLK_DIV) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CLK_DIV) @(negedge clk);
        check_state("break");
        send_frame(8'h33, 1'b1);
        check_state("after_break");

        // Start-bit glitch
        @(negedge clk);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CLK_DIV) @(negedge clk);
        check_state("glitch");
        send_frame(8'hA5, 1'b1);
        check_state("after_glitch");

        // Reset in the middle of the data bits
        @(negedge clk);
        rx = 1'b0;
        repeat (3 * CLK_DIV) @(negedge clk);
        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_clear();
        repeat (2 * CLK_DIV) @(negedge clk);
        check("midreset.rx_byte", {24'b0, rx_byte}, 32'd0);
        check_state("midreset");
        send_frame(8'h3C, 1'b1);
        check_state("after_midreset");

        // Clear in the rx_ready cycle
        hit = 1'b0;
        fork
            send_frame(8'h3D, 1'b1);
            begin
                for (int k = 0; k < 400 && !hit; k++) begin
                    @(negedge clk);
                    if (rx_ready === 1'b1) hit = 1'b1;
                end
                if (hit) begin
                    clear = 1'b1;
                    @(negedge clk);
                    clear = 1'b0;
                end
            end
        join
        check("clear_ready.seen", {31'b0, hit}, 32'd1);
        model_clear();
        check_state("clear_ready");
        send_frame(8'h90, 1'b1);
        check_state("relock");

        // Sequence-error counter saturation
        do_clear();
        for (int n = 0; n < 21; n++) send_frame(8'h00, 1'b1);
        check_state("saturate");

        check("final.scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
